// File: rtl/surf_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// surf_arb_pkg : shared types and constants for the SURF event arbiter
// Rev 1.0 - initial release (optional header beat: SURF_ARB_HDR_EN)
// ---------------------------------------------------------------------------
package surf_arb_pkg;

  localparam logic [4:0] HDR_TAG = 5'b10100;

  typedef logic [2:0] surf_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef SURF_ARB_HDR_EN
    ST_HDR  = 2'd1,
`endif
    ST_PASS = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/surf_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// surf_rr_pick : round-robin pick of the first request at or after ptr_i
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module surf_rr_pick
  import surf_arb_pkg::*;
#(
  parameter int NSURF = 7
) (
  input  logic [NSURF-1:0] req_i,
  input  surf_idx_t        ptr_i,
  output logic             found_o,
  output surf_idx_t        idx_o
);

  logic [2*NSURF-1:0] dbl_w;
  logic [NSURF-1:0]   rot_w;
  surf_idx_t          off_w;
  logic [3:0]         sum_w;

  // Rotating a doubled vector puts request ptr_i at bit 0.
  assign dbl_w = {req_i, req_i};
  assign rot_w = NSURF'(dbl_w >> ptr_i);

  always_comb begin
    found_o = 1'b0;
    off_w   = '0;
    for (int k = NSURF - 1; k >= 0; k--) begin
      if (rot_w[k]) begin
        found_o = 1'b1;
        off_w   = surf_idx_t'(k);
      end
    end
  end

  always_comb begin
    sum_w = {1'b0, ptr_i} + {1'b0, off_w};
    if (sum_w >= 4'(NSURF)) begin
      sum_w = sum_w - 4'(NSURF);
    end
    idx_o = sum_w[2:0];
  end

endmodule
`default_nettype wire

// File: rtl/surf_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// surf_event_arbiter : packet-level round-robin merge of NSURF byte streams
// Rev 1.0 - initial release; define SURF_ARB_HDR_EN for a per-packet header
// ---------------------------------------------------------------------------
module surf_event_arbiter
  import surf_arb_pkg::*;
#(
  parameter int         NSURF        = 7,
  parameter logic [6:0] DEFAULT_MASK = 7'h7F
) (
  input  logic               sysclk_i,
  input  logic               sysclk_rst_i,
  input  logic [NSURF-1:0]   enable_mask_i,
  input  logic [8*NSURF-1:0] s_tdata,
  input  logic [NSURF-1:0]   s_tvalid,
  output logic [NSURF-1:0]   s_tready,
  input  logic [NSURF-1:0]   s_tlast,
  output logic [7:0]         m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [2:0]         m_tuser,
  output logic               busy_o,
  output logic [NSURF-1:0]   pkt_done_o
);

  localparam logic [7:0]       MASK_EXT = {1'b0, DEFAULT_MASK};
  localparam logic [NSURF-1:0] MASK_RST = MASK_EXT[NSURF-1:0];
  localparam surf_idx_t        LAST_IDX = surf_idx_t'(NSURF - 1);

  arb_state_e       state_q, state_d;
  surf_idx_t        grant_q, grant_d;
  surf_idx_t        ptr_q, ptr_d;
  logic [NSURF-1:0] mask_q, mask_d;
  logic [NSURF-1:0] pkt_done_q, pkt_done_d;

  logic             pick_found_w;
  surf_idx_t        pick_idx_w;
  logic             cur_valid_w;
  logic             cur_last_w;
  logic             fire_w;

  // The mask input is live while idle so the decision sees the newest value.
  assign mask_d      = (state_q == ST_IDLE) ? enable_mask_i : mask_q;
  assign cur_valid_w = s_tvalid[grant_q];
  assign cur_last_w  = s_tlast[grant_q];
  assign fire_w      = (state_q == ST_PASS) && cur_valid_w && m_tready;

  surf_rr_pick #(
    .NSURF (NSURF)
  ) u_pick (
    .req_i   (s_tvalid & mask_d),
    .ptr_i   (ptr_q),
    .found_o (pick_found_w),
    .idx_o   (pick_idx_w)
  );

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      mask_q     <= MASK_RST;
      pkt_done_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    pkt_done_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_w) begin
          grant_d = pick_idx_w;
`ifdef SURF_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_PASS;
`endif
        end
      end
`ifdef SURF_ARB_HDR_EN
      ST_HDR: begin
        if (m_tready) begin
          state_d = ST_PASS;
        end
      end
`endif
      ST_PASS: begin
        if (fire_w && cur_last_w) begin
          state_d             = ST_IDLE;
          ptr_d               = (grant_q == LAST_IDX) ? '0 : grant_q + 3'd1;
          pkt_done_d[grant_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    s_tready = '0;
    busy_o   = (state_q != ST_IDLE);
    case (state_q)
`ifdef SURF_ARB_HDR_EN
      ST_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {HDR_TAG, grant_q};
        m_tuser  = grant_q;
      end
`endif
      ST_PASS: begin
        m_tvalid          = cur_valid_w;
        m_tdata           = s_tdata[{grant_q, 3'b000} +: 8];
        m_tlast           = cur_last_w;
        m_tuser           = grant_q;
        s_tready[grant_q] = m_tready;
      end
      default: ;
    endcase
  end

  assign pkt_done_o = pkt_done_q;

endmodule
`default_nettype wire

// File: tb/tb_surf_event_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_surf_event_arbiter : directed scoreboard bench for surf_event_arbiter
// Rev 1.0 - initial release (header beats expected when SURF_ARB_HDR_EN set)
// ---------------------------------------------------------------------------
module tb_surf_event_arbiter;

  localparam int NS = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS-1:0]   enable_mask = 7'h7F;
  logic [8*NS-1:0] s_tdata = '0;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tready;
  logic [NS-1:0]   s_tlast = '0;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic            m_tlast;
  logic [2:0]      m_tuser;
  logic            busy;
  logic [NS-1:0]   pkt_done;

  always #5 clk = ~clk;

  surf_event_arbiter #(
    .NSURF        (NS),
    .DEFAULT_MASK (7'h7F)
  ) dut (
    .sysclk_i      (clk),
    .sysclk_rst_i  (rst),
    .enable_mask_i (enable_mask),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tuser       (m_tuser),
    .busy_o        (busy),
    .pkt_done_o    (pkt_done)
  );

  // Source model: per-SURF queue of {last, data}; expected beats {user, last, data}.
  logic [8:0]  srcq [NS][$];
  logic [11:0] expq [$];
  bit          gap [NS];
  int          pkt_cnt [NS];
  logic [NS-1:0] allow_mask = '1;
  int  n_vec = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  bit  prev_last = 1'b1;
  bit  gap_chk = 1'b0;
  bit  have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    logic [8:0] h;
    for (int i = 0; i < NS; i++) begin
      h = '0;
      if (srcq[i].size() > 0) h = srcq[i][0];
      s_tvalid[i]      = (srcq[i].size() > 0) && !gap[i];
      s_tdata[i*8 +: 8] = h[7:0];
      s_tlast[i]       = h[8];
    end
  endtask

  task automatic tick();
    logic [NS-1:0] acc;
    logic [11:0]   e;
    refresh();
    @(negedge clk);
    for (int i = 0; i < NS; i++) pkt_cnt[i] += int'(pkt_done[i]);
    check("tready_onehot", 32'($onehot0(s_tready)), 32'd1);
    check("tready_other", 32'(s_tready & ~allow_mask), 32'd0);
    if (m_tvalid && m_tready) begin
      check("beat_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("beat", {20'd0, m_tuser, m_tlast, m_tdata}, {20'd0, e});
      end
      if (prev_last && gap_chk && have_prev) check("idle_gap", cyc - last_cyc, 32'd2);
      if (m_tlast) begin
        last_cyc  = cyc;
        have_prev = gap_chk;
      end
      prev_last = m_tlast;
    end
    acc = s_tready & s_tvalid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    cyc++;
  endtask

  task automatic expect_pkt(input int s, input int nbeats, input int len, input logic [7:0] base);
`ifdef SURF_ARB_HDR_EN
    expq.push_back({3'(s), 1'b0, 5'b10100, 3'(s)});
`endif
    for (int k = 0; k < nbeats; k++) expq.push_back({3'(s), k == len - 1, base + 8'(k)});
  endtask

  task automatic push_pkt(input int s, input int len, input logic [7:0] base, input bit exp_too);
    for (int k = 0; k < len; k++) srcq[s].push_back({k == len - 1, base + 8'(k)});
    if (exp_too) expect_pkt(s, len, len, base);
  endtask

  task automatic run_drain(input string tag, input int maxc);
    int n = 0;
    while ((expq.size() > 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, expq.size(), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mvalid", 32'(m_tvalid), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    rst = 1'b0;

    // Fairness: 0, 3, 5 from ptr 0, one idle cycle between packets
    m_tready = 1'b1;
    gap_chk  = 1'b1;
    push_pkt(0, 4, 8'h00, 1'b1);
    push_pkt(3, 4, 8'h30, 1'b1);
    push_pkt(5, 4, 8'h50, 1'b1);
    run_drain("fair_drain", 60);
    gap_chk = 1'b0;

    // Wrap: ptr 6 -> grant 6 then 1; ptr then 2 so 2 beats 0
    push_pkt(6, 2, 8'h60, 1'b1);
    push_pkt(1, 2, 8'h10, 1'b1);
    run_drain("wrap_drain", 40);
    push_pkt(2, 2, 8'h20, 1'b1);
    push_pkt(0, 2, 8'h05, 1'b1);
    run_drain("wrap_ptr_drain", 40);

    // Mask change mid-packet on SURF 1
    for (int i = 0; i < NS; i++) pkt_cnt[i] = 0;
    push_pkt(1, 4, 8'hA0, 1'b1);
    n = 0;
    while (srcq[1].size() > 2 && n < 20) begin
      tick();
      n++;
    end
    enable_mask = 7'h7D;
    push_pkt(1, 2, 8'hB0, 1'b0);
    push_pkt(2, 2, 8'hC0, 1'b1);
    run_drain("mask_drain", 40);
    repeat (4) tick();
    check("mask_skip", srcq[1].size(), 32'd2);
    check("mask_done1", pkt_cnt[1], 32'd1);
    check("mask_idle", 32'(busy), 32'd0);
    enable_mask = 7'h7F;
    expect_pkt(1, 2, 2, 8'hB0);
    run_drain("unmask_drain", 40);
    check("unmask_done1", pkt_cnt[1], 32'd2);

    // Backpressure with source gaps on SURF 2
    allow_mask = 7'h04;
    push_pkt(2, 6, 8'h11, 1'b1);
    for (int c = 0; c < 60 && (expq.size() > 0 || busy); c++) begin
      m_tready = (c % 2 == 0);
      gap[2]   = (c % 3 == 1);
      tick();
    end
    gap[2]   = 1'b0;
    m_tready = 1'b1;
    check("bp_drain", expq.size(), 32'd0);
    allow_mask = '1;
    tick();

    // Reset on byte 3 of an 8-byte SURF 3 packet
    push_pkt(3, 8, 8'h80, 1'b0);
    expect_pkt(3, 2, 8, 8'h80);
    n = 0;
    while (srcq[3].size() > 6 && n < 20) begin
      tick();
      n++;
    end
    check("rst_partial", expq.size(), 32'd0);
    refresh();
    #2;
    rst = 1'b1;
    #1;
    check("arst_mvalid", 32'(m_tvalid), 32'd0);
    check("arst_mlast", 32'(m_tlast), 32'd0);
    check("arst_tready", 32'(s_tready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(pkt_done), 32'd0);
    srcq[3].delete();
    refresh();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd0);
    push_pkt(0, 2, 8'hE0, 1'b1);
    push_pkt(4, 2, 8'hE4, 1'b1);
    run_drain("post_rst_drain", 40);

`ifdef SURF_ARB_HDR_EN
    // Header build: A4 then two data bytes, all tagged with SURF 4
    push_pkt(4, 2, 8'hD0, 1'b1);
    run_drain("hdr_drain", 40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/surf_event_arbiter.md
SURF_EVENT_ARBITER -- requirements
Module: surf_event_arbiter

Interface
REQ-001 SHALL have parameter NSURF, default 7, number of SURF input streams (1..8).
REQ-002 SHALL have parameter [6:0] DEFAULT_MASK, default 7'h7F, reset value of the internal enable mask.
REQ-003 SHALL have port sysclk_i  input  1  system clock; all logic runs in this single clock domain.
REQ-004 SHALL have port sysclk_rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable_mask_i  input  NSURF  per-SURF enable, sampled only when the arbiter is in IDLE.
REQ-006 SHALL have port s_tdata  input  8*NSURF  SURF data, with byte i belonging to SURF i.
REQ-007 SHALL have ports s_tvalid, s_tready and s_tlast, each NSURF wide, with s_tready as the output; these are the per-SURF AXI4-Stream handshake.
REQ-008 SHALL have port m_tdata  output  8  merged data.
REQ-009 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1) for the merged stream handshake.
REQ-010 SHALL have port m_tuser  output  3  index of the granted SURF.
REQ-011 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port pkt_done_o  output  NSURF  one-cycle pulse on the bit of the SURF whose tlast byte was accepted.

Function
REQ-013 SHALL implement the states IDLE, HDR (present only when SURF_ARB_HDR_EN is defined) and PASS.
REQ-014 In IDLE, the arbiter SHALL grant the first SURF i, searching from ptr upward with wrap NSURF-1->0, for which s_tvalid[i] and mask[i] are both high.
- Grant is registered.
- The next state is HDR or PASS.
- With no candidate, the arbiter stays in IDLE.
REQ-015 In IDLE, all s_tready SHALL be 0, m_tvalid SHALL be 0, and the latched mask SHALL be updated from enable_mask_i.
REQ-016 In PASS, the datapath SHALL be combinational.
- m_tdata = s_tdata[grant], m_tvalid = s_tvalid[grant], m_tlast = s_tlast[grant].
- s_tready[grant] = m_tready; all other s_tready bits are 0.
REQ-017 On a PASS handshake with s_tlast[grant] high, the arbiter SHALL:
- go to IDLE;
- set ptr = grant+1, wrapping NSURF-1 to 0;
- pulse pkt_done_o[grant] in the following cycle.
REQ-018 Arbitration latency SHALL be exactly one IDLE cycle between the end of one packet and the first byte of the next packet.
REQ-019 m_tuser SHALL equal grant in HDR and PASS, and 0 in IDLE.
REQ-020 Changes to enable_mask_i mid-packet SHALL NOT affect the packet in progress; a masked SURF is skipped only at the next IDLE decision.
REQ-021 When s_tvalid[grant] is low mid-packet, the arbiter SHALL hold the grant indefinitely (no timeout).
REQ-022 The grant and ptr registers SHALL be 3 bits wide, and values at or above NSURF SHALL never be produced.

Reset
REQ-023 On sysclk_rst_i assertion, including mid-packet, the arbiter SHALL asynchronously force:
- state to IDLE;
- ptr and grant to 0;
- mask to DEFAULT_MASK;
- pkt_done_o to 0.
REQ-024 During reset, all s_tready, m_tvalid, m_tlast and busy_o SHALL be 0; a truncated packet is not resumed.

Configuration
REQ-025 With macro SURF_ARB_HDR_EN defined, the grant SHALL enter HDR and drive m_tvalid=1, m_tdata={5'b10100, grant}, m_tlast=0 and all s_tready=0 until m_tready, then go to PASS.
REQ-026 Without SURF_ARB_HDR_EN, the HDR state and its logic SHALL be absent and IDLE SHALL go directly to PASS.

Structure
REQ-027 A shared package surf_arb_pkg SHALL hold:
- the state enum;
- the constant HDR_TAG = 5'b10100;
- the 3-bit index typedef.
REQ-028 The priority search SHALL be one sub-module, surf_rr_pick (combinational rotate, priority encode and unrotate), and all other logic SHALL be inline.

Verification
REQ-029 Fairness: SURFs 0, 3 and 5 each hold a 4-byte packet with ptr=0, m_tready=1.
- Required output order: 0, 3, 5.
- Each packet is 4 bytes with m_tlast on byte 4.
- Exactly one idle cycle between packets.
REQ-030 Wrap: with ptr=6 after a SURF 5 packet, and SURFs 6 and 1 valid, the arbiter grants 6, then 1, and ptr ends at 2.
REQ-031 Mask: enable_mask_i=7'h7D is applied mid-packet on SURF 1.
- The current packet completes.
- A next pending SURF 1 packet is skipped.
- pkt_done_o[1] pulses once.
REQ-032 Backpressure: m_tready is toggled 1,0,1,0 while s_tvalid[2] gaps.
- All 6 bytes 0x11..0x16 arrive in order with no duplication.
- s_tready is never high on another SURF.
REQ-033 Reset mid-packet: sysclk_rst_i is asserted on byte 3 of 8.
- Outputs go to 0 asynchronously.
- After release, busy_o=0 and the next grant starts from SURF 0.
REQ-034 HDR build: a SURF 4 packet of 2 bytes produces m_tdata 0xA4, then the 2 data bytes, with m_tuser=4 on all 3 beats.
